// File: rtl/corefifo_sync_pkg.sv
// rtl/corefifo_sync_pkg.sv - shared pointer width, pointer type and Gray/binary conversion
// Purpose: single source for the pointer width of the Gray pointer synchroniser.
// Contents: PKG_ADDRWIDTH / PW localparams, ptr_t, gray2bin(), bin2gray().
package corefifo_sync_pkg;

    localparam int PKG_ADDRWIDTH = 3;
    localparam int PW            = PKG_ADDRWIDTH + 1;

    typedef logic [PW-1:0] ptr_t;

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/corefifo_gray_ch_check.sv
// rtl/corefifo_gray_ch_check.sv - one channel: sync chain, Gray decode and step checker
// Purpose: synchronise one Gray pointer and only let it advance by a legal forward step.
// Ports:
//   clk, srstn  clock, synchronous active-low reset
//   en          1 = check mode, 0 = track mode
//   err_clr     clear for the sticky err bit (a simultaneous rejection wins)
//   inp         asynchronous Gray pointer
//   sync_gray   accepted pointer, Gray
//   sync_bin    accepted pointer, binary
//   upd         one-cycle pulse when the accepted pointer changes
//   err         sticky flag: an illegal step was rejected
module corefifo_gray_ch_check
    import corefifo_sync_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int MAX_STEP   = 1
) (
    input  logic clk,
    input  logic srstn,
    input  logic en,
    input  logic err_clr,
    input  ptr_t inp,
    output ptr_t sync_gray,
    output ptr_t sync_bin,
    output logic upd,
    output logic err
);

    // MAX_STEP <= 2^(PW-1), so it always fits the pointer width.
    localparam ptr_t MAX_STEP_P = ptr_t'(MAX_STEP);

    ptr_t stage [NUM_STAGES];
    ptr_t s;
    ptr_t b_new;
    ptr_t delta;
    logic accept;
    logic reject;

    always_ff @(posedge clk) begin
        if (!srstn) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= inp;
            for (int i = 1; i < NUM_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign s     = stage[NUM_STAGES-1];
    assign b_new = gray2bin(s);
    // Modulo subtraction: wrap 2^PW-1 -> 0 gives 1, backward moves give large values.
    assign delta = b_new - sync_bin;

    always_comb begin
        accept = 1'b0;
        reject = 1'b0;
        if (en) begin
            accept = (delta != '0) && (delta <= MAX_STEP_P);
            reject = (delta > MAX_STEP_P);
        end else begin
            // Track mode follows the chain so that check mode resumes from a fresh reference.
            accept = (s != sync_gray);
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            sync_gray <= '0;
            sync_bin  <= '0;
            upd       <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                sync_gray <= s;
                sync_bin  <= b_new;
            end
            upd <= accept;
            if (reject) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/corefifo_gray_ptr_sync.sv
// rtl/corefifo_gray_ptr_sync.sv - multi-channel Gray pointer synchroniser with step checking
// Purpose: bring NUM_CH remote Gray pointers into clk, decode them and reject illegal jumps.
// Ports:
//   clk, srstn  clock, synchronous active-low reset
//   en          1 = check mode, 0 = track mode (shared by all channels)
//   err_clr     per-channel clear of err
//   inp         asynchronous Gray pointers, channel c at [c*PW +: PW]
//   sync_gray   accepted pointers, Gray
//   sync_bin    accepted pointers, binary
//   upd         per-channel change pulse
//   err         per-channel sticky rejection flag
module corefifo_gray_ptr_sync
    import corefifo_sync_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int ADDRWIDTH  = 3,
    parameter int NUM_CH     = 1,
    parameter int MAX_STEP   = 1
) (
    input  logic                            clk,
    input  logic                            srstn,
    input  logic                            en,
    input  logic [NUM_CH-1:0]               err_clr,
    input  logic [NUM_CH*(ADDRWIDTH+1)-1:0] inp,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] sync_gray,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] sync_bin,
    output logic [NUM_CH-1:0]               upd,
    output logic [NUM_CH-1:0]               err
);

    // The conversion functions are sized by the package, so the instance must agree with it.
    if (ADDRWIDTH != PKG_ADDRWIDTH) begin : g_bad_addrwidth
        $error("ADDRWIDTH must match corefifo_sync_pkg::PKG_ADDRWIDTH");
    end
    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("NUM_STAGES must be at least 2");
    end
    if (MAX_STEP < 1 || MAX_STEP > (1 << ADDRWIDTH)) begin : g_bad_step
        $error("MAX_STEP must be in 1..2^ADDRWIDTH");
    end
    if (NUM_CH < 1) begin : g_bad_ch
        $error("NUM_CH must be at least 1");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        corefifo_gray_ch_check #(
            .NUM_STAGES (NUM_STAGES),
            .MAX_STEP   (MAX_STEP)
        ) u_ch (
            .clk       (clk),
            .srstn     (srstn),
            .en        (en),
            .err_clr   (err_clr[c]),
            .inp       (inp[c*PW +: PW]),
            .sync_gray (sync_gray[c*PW +: PW]),
            .sync_bin  (sync_bin[c*PW +: PW]),
            .upd       (upd[c]),
            .err       (err[c])
        );
    end

endmodule

// File: tb/tb_corefifo_gray_ptr_sync.sv
// tb/tb_corefifo_gray_ptr_sync.sv - directed self-checking bench for corefifo_gray_ptr_sync
module tb_corefifo_gray_ptr_sync;

    logic       clk = 1'b0;
    logic       srstn;
    logic       en;
    logic [1:0] err_clr;
    logic [7:0] inp;
    logic [7:0] sync_gray;
    logic [7:0] sync_bin;
    logic [1:0] upd;
    logic [1:0] err;

    int total = 0;
    int bad   = 0;

    corefifo_gray_ptr_sync #(
        .NUM_STAGES (2),
        .ADDRWIDTH  (3),
        .NUM_CH     (2),
        .MAX_STEP   (1)
    ) dut (
        .clk       (clk),
        .srstn     (srstn),
        .en        (en),
        .err_clr   (err_clr),
        .inp       (inp),
        .sync_gray (sync_gray),
        .sync_bin  (sync_bin),
        .upd       (upd),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] v);
        srstn   = 1'b0;
        inp     = v;
        err_clr = 2'b00;
        step(3);
        srstn = 1'b1;
    endtask

    task automatic test_reset;
        en = 1'b1;
        do_reset(8'hFF);
        total++; if (sync_gray !== 8'h00) begin bad++; $display("FAIL reset_gray got=%h exp=00", sync_gray); end
        total++; if (sync_bin  !== 8'h00) begin bad++; $display("FAIL reset_bin got=%h exp=00", sync_bin); end
        total++; if (upd !== 2'b00) begin bad++; $display("FAIL reset_upd got=%b exp=00", upd); end
        total++; if (err !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", err); end
        step(2);
        total++; if (err !== 2'b00) begin bad++; $display("FAIL reset_err_early got=%b exp=00", err); end
        step(1);
        total++; if (err !== 2'b11) begin bad++; $display("FAIL reset_err_late got=%b exp=11", err); end
        total++; if (sync_bin !== 8'h00) begin bad++; $display("FAIL reset_bin_held got=%h exp=00", sync_bin); end
        total++; if (upd !== 2'b00) begin bad++; $display("FAIL reset_upd_held got=%b exp=00", upd); end
        // Mid-operation reset clears the sticky err.
        do_reset(8'h00);
        total++; if (err !== 2'b00) begin bad++; $display("FAIL reset_mid_err got=%b exp=00", err); end
    endtask

    task automatic test_latency;
        en = 1'b1;
        do_reset(8'h00);
        inp = 8'h01;
        step(2);
        total++; if (upd !== 2'b00) begin bad++; $display("FAIL lat_upd_early got=%b exp=00", upd); end
        total++; if (sync_bin !== 8'h00) begin bad++; $display("FAIL lat_bin_early got=%h exp=00", sync_bin); end
        step(1);
        total++; if (sync_bin !== 8'h01) begin bad++; $display("FAIL lat_bin got=%h exp=01", sync_bin); end
        total++; if (sync_gray !== 8'h01) begin bad++; $display("FAIL lat_gray got=%h exp=01", sync_gray); end
        total++; if (upd !== 2'b01) begin bad++; $display("FAIL lat_upd got=%b exp=01", upd); end
        step(1);
        total++; if (upd !== 2'b00) begin bad++; $display("FAIL lat_upd_pulse got=%b exp=00", upd); end
    endtask

    task automatic test_wrap;
        logic [3:0] gray_seq [4];
        logic [3:0] bin_seq  [4];
        int pulses;
        gray_seq[0] = 4'd11; bin_seq[0] = 4'd13;
        gray_seq[1] = 4'd9;  bin_seq[1] = 4'd14;
        gray_seq[2] = 4'd8;  bin_seq[2] = 4'd15;
        gray_seq[3] = 4'd0;  bin_seq[3] = 4'd0;
        en  = 1'b0;
        inp = 8'h0A;            // gray(12)
        step(4);
        en = 1'b1;
        total++; if (sync_bin !== 8'h0C) begin bad++; $display("FAIL wrap_start got=%h exp=0c", sync_bin); end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            inp = {4'h0, gray_seq[i]};
            for (int k = 0; k < 4; k++) begin
                step(1);
                if (upd[0]) pulses++;
            end
            total++;
            if (sync_bin !== {4'h0, bin_seq[i]}) begin
                bad++; $display("FAIL wrap_bin step=%0d got=%h exp=%h", i, sync_bin, bin_seq[i]);
            end
        end
        total++; if (pulses != 4) begin bad++; $display("FAIL wrap_pulses got=%0d exp=4", pulses); end
        total++; if (err !== 2'b00) begin bad++; $display("FAIL wrap_err got=%b exp=00", err); end
    endtask

    task automatic test_illegal;
        en  = 1'b0;
        inp = 8'h07;            // gray(5)
        step(4);
        en = 1'b1;
        total++; if (sync_bin !== 8'h05) begin bad++; $display("FAIL ill_start got=%h exp=05", sync_bin); end
        inp = 8'h0D;            // gray(9)
        step(3);
        total++; if (sync_bin !== 8'h05) begin bad++; $display("FAIL ill_fwd_bin got=%h exp=05", sync_bin); end
        total++; if (upd !== 2'b00) begin bad++; $display("FAIL ill_fwd_upd got=%b exp=00", upd); end
        total++; if (err !== 2'b01) begin bad++; $display("FAIL ill_fwd_err got=%b exp=01", err); end
        inp = 8'h07;
        step(3);
        err_clr = 2'b01;
        step(1);
        err_clr = 2'b00;
        total++; if (err !== 2'b00) begin bad++; $display("FAIL ill_clr got=%b exp=00", err); end
        inp = 8'h02;            // gray(3)
        step(3);
        total++; if (sync_bin !== 8'h05) begin bad++; $display("FAIL ill_bwd_bin got=%h exp=05", sync_bin); end
        total++; if (upd !== 2'b00) begin bad++; $display("FAIL ill_bwd_upd got=%b exp=00", upd); end
        total++; if (err !== 2'b01) begin bad++; $display("FAIL ill_bwd_err got=%b exp=01", err); end
    endtask

    task automatic test_clear_race;
        // inp still gray(3): every cycle is a fresh rejection.
        err_clr = 2'b01;
        step(1);
        err_clr = 2'b00;
        total++; if (err !== 2'b01) begin bad++; $display("FAIL race_set_wins got=%b exp=01", err); end
        inp = 8'h07;
        step(3);
        total++; if (err !== 2'b01) begin bad++; $display("FAIL race_sticky got=%b exp=01", err); end
        err_clr = 2'b01;
        step(1);
        err_clr = 2'b00;
        total++; if (err !== 2'b00) begin bad++; $display("FAIL race_clr got=%b exp=00", err); end
        total++; if (sync_bin !== 8'h05) begin bad++; $display("FAIL race_bin got=%h exp=05", sync_bin); end
    endtask

    task automatic test_track_multi;
        en = 1'b0;
        do_reset(8'h00);
        inp = 8'h0D;            // ch0 gray(9), ch1 0
        step(3);
        total++; if (sync_bin !== 8'h09) begin bad++; $display("FAIL trk_bin got=%h exp=09", sync_bin); end
        total++; if (upd !== 2'b01) begin bad++; $display("FAIL trk_upd got=%b exp=01", upd); end
        total++; if (err !== 2'b00) begin bad++; $display("FAIL trk_err got=%b exp=00", err); end
        step(1);
        en = 1'b1;
        step(1);
        total++; if (err !== 2'b00) begin bad++; $display("FAIL trk_enrise_err got=%b exp=00", err); end
        inp = 8'h0F;            // ch0 gray(10)
        step(3);
        total++; if (sync_bin !== 8'h0A) begin bad++; $display("FAIL trk_step_bin got=%h exp=0a", sync_bin); end
        total++; if (sync_gray !== 8'h0F) begin bad++; $display("FAIL trk_step_gray got=%h exp=0f", sync_gray); end
        total++; if (upd !== 2'b01) begin bad++; $display("FAIL trk_step_upd got=%b exp=01", upd); end
        total++; if (err !== 2'b00) begin bad++; $display("FAIL trk_step_err got=%b exp=00", err); end
    endtask

    initial begin
        srstn   = 1'b0;
        en      = 1'b1;
        err_clr = 2'b00;
        inp     = 8'h00;
        #1;
        test_reset();
        test_latency();
        test_wrap();
        test_illegal();
        test_clear_race();
        test_track_multi();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
